// File: rtl/rx_port_sink.sv
// rx_port_sink: consumer of one router output channel.
// Accepts packets over the validrx/ackrx four-phase handshake, buffers them
// in a 2**DEPTH-entry FIFO with a first-word-fall-through read port, and
// counts accepted packets.
// Optional feature macro: RX_ADR_CHECK_EN -- when defined, packets whose
// address field differs from LOCAL_ADR are acknowledged but dropped and
// counted in err_cnt_o; when undefined err_cnt_o is tied to 0.
module rx_port_sink #(
  parameter int unsigned DW        = 4,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned CW        = 8,
  parameter logic [2:0]  LOCAL_ADR = 3'b000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [DW+2:0]   rx_dat_i,
  input  logic            validrx,
  output logic            ackrx,
  input  logic            rd_en_i,
  output logic [DW+2:0]   rd_dat_o,
  output logic            empty_o,
  output logic            full_o,
  output logic [CW-1:0]   pkt_cnt_o,
  output logic [CW-1:0]   err_cnt_o
);

  localparam int unsigned PW   = DW + 3;
  localparam int unsigned PTRW = DEPTH + 1;
  localparam int unsigned NENT = 1 << DEPTH;

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              ackrx_q, ackrx_d;
  logic [PTRW-1:0]   wptr_q, wptr_d;
  logic [PTRW-1:0]   rptr_q, rptr_d;
  logic [PW-1:0]     mem_q [NENT];
  logic [PW-1:0]     mem_d [NENT];
  logic [CW-1:0]     pkt_cnt_q, pkt_cnt_d;

  logic              req_idle;
  logic              adr_ok;
  logic              push;
  logic              pop;

  // Pointer-derived FIFO status; full is sampled before any same-cycle pop.
  assign empty_o  = (wptr_q == rptr_q);
  assign full_o   = (wptr_q[DEPTH] != rptr_q[DEPTH]) &&
                    (wptr_q[DEPTH-1:0] == rptr_q[DEPTH-1:0]);
  assign rd_dat_o = mem_q[rptr_q[DEPTH-1:0]];

  assign req_idle = (state_q == IDLE) && validrx;
  assign push     = req_idle && adr_ok && !full_o;
  assign pop      = rd_en_i && !empty_o;

`ifdef RX_ADR_CHECK_EN
  logic            drop;
  logic [CW-1:0]   err_cnt_q, err_cnt_d;

  assign adr_ok    = (rx_dat_i[PW-1:DW] == LOCAL_ADR);
  assign drop      = req_idle && !adr_ok;
  assign err_cnt_o = err_cnt_q;

  // Count dropped packets on their drop cycle only.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (drop) err_cnt_d = err_cnt_q + CW'(1);
  end

  // Error counter register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end
`else
  logic drop;
  logic unused_local_adr;

  assign adr_ok           = 1'b1;
  assign drop             = 1'b0;
  assign err_cnt_o        = '0;
  assign unused_local_adr = ^LOCAL_ADR;
`endif

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: one capture (or drop) per four-phase cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (push || drop) state_d = ACK;
      ACK:     if (!validrx)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output: acknowledge is the registered image of the ACK state.
  always_comb begin
    ackrx_d = 1'b0;
    if (state_d == ACK) ackrx_d = 1'b1;
  end

  assign ackrx = ackrx_q;

  // FIFO pointers, storage and packet counter next values.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    mem_d     = mem_q;
    pkt_cnt_d = pkt_cnt_q;
    if (push) begin
      mem_d[wptr_q[DEPTH-1:0]] = rx_dat_i;
      wptr_d                   = wptr_q + PTRW'(1);
      pkt_cnt_d                = pkt_cnt_q + CW'(1);
    end
    if (pop) rptr_d = rptr_q + PTRW'(1);
  end

  // Datapath and handshake registers; storage clears so the head reads 0 after reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ackrx_q   <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      pkt_cnt_q <= '0;
      for (int i = 0; i < int'(NENT); i++) mem_q[i] <= '0;
    end else begin
      ackrx_q   <= ackrx_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      pkt_cnt_q <= pkt_cnt_d;
      for (int i = 0; i < int'(NENT); i++) mem_q[i] <= mem_d[i];
    end
  end

  assign pkt_cnt_o = pkt_cnt_q;

endmodule

// File: tb/tb_rx_port_sink.sv
// Directed bench for rx_port_sink (DW=4, DEPTH=2). Inputs change and outputs
// are sampled 1 time unit after the rising clock edge.
module tb_rx_port_sink;

  logic       clk_i;
  logic       rst_i;
  logic [6:0] rx_dat_i;
  logic       validrx;
  logic       ackrx;
  logic       rd_en_i;
  logic [6:0] rd_dat_o;
  logic       empty_o;
  logic       full_o;
  logic [7:0] pkt_cnt_o;
  logic [7:0] err_cnt_o;

  int n_vec;
  int n_err;
  int lat;

`ifdef RX_ADR_CHECK_EN
  localparam logic [2:0] TB_ADR = 3'b101;
`else
  localparam logic [2:0] TB_ADR = 3'b000;
`endif

  rx_port_sink #(.DW(4), .DEPTH(2), .CW(8), .LOCAL_ADR(TB_ADR)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rx_dat_i  (rx_dat_i),
    .validrx   (validrx),
    .ackrx     (ackrx),
    .rd_en_i   (rd_en_i),
    .rd_dat_o  (rd_dat_o),
    .empty_o   (empty_o),
    .full_o    (full_o),
    .pkt_cnt_o (pkt_cnt_o),
    .err_cnt_o (err_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    validrx  = 1'b0;
    rd_en_i  = 1'b0;
    rx_dat_i = '0;
    rst_i    = 1'b0;
    step();
    step();
    rst_i = 1'b1;
    step();
  endtask

  // Raise validrx, return cycles until ackrx (99 on timeout), then finish the handshake.
  task automatic send(input logic [6:0] d, output int cycles);
    rx_dat_i = d;
    validrx  = 1'b1;
    cycles   = 99;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (ackrx === 1'b1) begin
        cycles = i;
        break;
      end
    end
    validrx = 1'b0;
    step();
    chk("ack_release", 32'(ackrx), 0);
  endtask

  task automatic pop_once();
    rd_en_i = 1'b1;
    step();
    rd_en_i = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Reset state
    rst_i    = 1'b0;
    validrx  = 1'b0;
    rd_en_i  = 1'b0;
    rx_dat_i = '0;
    #12;
    chk("rst_ackrx", 32'(ackrx), 0);
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_full", 32'(full_o), 0);
    chk("rst_rd_dat", 32'(rd_dat_o), 0);
    chk("rst_pkt_cnt", 32'(pkt_cnt_o), 0);
    chk("rst_err_cnt", 32'(err_cnt_o), 0);
    #5;
    rst_i = 1'b1;
    step();

    // Empty read: pops ignored
    rd_en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("empty_rd_empty", 32'(empty_o), 1);
      chk("empty_rd_dat", 32'(rd_dat_o), 0);
    end
    rd_en_i = 1'b0;
    send(7'h11, lat);
    chk("empty_rd_lat", 32'(lat), 1);
    chk("empty_rd_head", 32'(rd_dat_o), 'h11);
    chk("empty_rd_notempty", 32'(empty_o), 0);
    pop_once();
    chk("empty_rd_after_pop", 32'(empty_o), 1);

    // Single packet
    do_reset();
    rx_dat_i = 7'h2A;
    validrx  = 1'b1;
    chk("single_ack_pre", 32'(ackrx), 0);
    step();
    chk("single_ack_1cyc", 32'(ackrx), 1);
    chk("single_pkt_cnt", 32'(pkt_cnt_o), 1);
    step();
    chk("single_ack_hold", 32'(ackrx), 1);
    chk("single_no_double", 32'(pkt_cnt_o), 1);
    validrx = 1'b0;
    step();
    chk("single_ack_drop", 32'(ackrx), 0);
    chk("single_empty", 32'(empty_o), 0);
    chk("single_head", 32'(rd_dat_o), 'h2A);

    // Fill and backpressure
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      send(7'(i), lat);
      chk("fill_lat", 32'(lat), 1);
    end
    chk("fill_full", 32'(full_o), 1);
    chk("fill_pkt_cnt", 32'(pkt_cnt_o), 4);
    rx_dat_i = 7'h05;
    validrx  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_ack_low", 32'(ackrx), 0);
    end
    chk("bp_pkt_cnt", 32'(pkt_cnt_o), 4);
    chk("bp_head", 32'(rd_dat_o), 'h01);
    pop_once();
    chk("bp_pop_no_capture", 32'(ackrx), 0);
    chk("bp_pop_notfull", 32'(full_o), 0);
    chk("bp_pop_head", 32'(rd_dat_o), 'h02);
    step();
    chk("bp_capture_ack", 32'(ackrx), 1);
    chk("bp_capture_cnt", 32'(pkt_cnt_o), 5);
    chk("bp_capture_full", 32'(full_o), 1);
    validrx = 1'b0;
    step();
    chk("bp_ack_release", 32'(ackrx), 0);
    for (int i = 2; i <= 5; i++) begin
      chk("bp_read_order", 32'(rd_dat_o), 32'(i));
      pop_once();
    end
    chk("bp_drained", 32'(empty_o), 1);

    // Simultaneous read/write
    do_reset();
    send(7'h31, lat);
    send(7'h32, lat);
    rx_dat_i = 7'h33;
    validrx  = 1'b1;
    rd_en_i  = 1'b1;
    step();
    rd_en_i = 1'b0;
    chk("rw_ack", 32'(ackrx), 1);
    chk("rw_full", 32'(full_o), 0);
    chk("rw_head", 32'(rd_dat_o), 'h32);
    validrx = 1'b0;
    step();
    pop_once();
    chk("rw_third", 32'(rd_dat_o), 'h33);
    pop_once();
    chk("rw_count2_empty", 32'(empty_o), 1);

    // Reset mid-handshake
    do_reset();
    rx_dat_i = 7'h44;
    validrx  = 1'b1;
    step();
    chk("mid_ack", 32'(ackrx), 1);
    rst_i = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(ackrx), 0);
    chk("mid_rst_empty", 32'(empty_o), 1);
    chk("mid_rst_cnt", 32'(pkt_cnt_o), 0);
    #3;
    rst_i = 1'b1;
    step();
    chk("mid_recapture_ack", 32'(ackrx), 1);
    chk("mid_recapture_cnt", 32'(pkt_cnt_o), 1);
    chk("mid_recapture_head", 32'(rd_dat_o), 'h44);
    validrx = 1'b0;
    step();
    chk("mid_ack_release", 32'(ackrx), 0);

    // Address check
    do_reset();
    send(7'h5A, lat);
    chk("adr_match_lat", 32'(lat), 1);
    send(7'h3A, lat);
`ifdef RX_ADR_CHECK_EN
    chk("adr_miss_lat", 32'(lat), 1);
    chk("adr_pkt_cnt", 32'(pkt_cnt_o), 1);
    chk("adr_err_cnt", 32'(err_cnt_o), 1);
    chk("adr_head", 32'(rd_dat_o), 'h5A);
    pop_once();
    chk("adr_only_one", 32'(empty_o), 1);
`else
    chk("noadr_lat", 32'(lat), 1);
    chk("noadr_pkt_cnt", 32'(pkt_cnt_o), 2);
    chk("noadr_err_cnt", 32'(err_cnt_o), 0);
    chk("noadr_head", 32'(rd_dat_o), 'h5A);
    pop_once();
    chk("noadr_second", 32'(rd_dat_o), 'h3A);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
